wb_regfile: RTL
===============

# wb_regfile

Architectural register file at the far end of the writeback path: it consumes the 32-bit writeback value from the WB stage together with its destination register and write enable, and serves the two operand reads in the ID stage. Provides 32 x 32-bit registers with $0 hardwired to zero and same-cycle write-to-read bypass, so a writeback and a dependent decode in the same cycle need no extra forwarding. Also provides a registered debug read port and a commit counter for the board display and testbenches.

## Interface
- SP_RESET, 32'h0000_03FC, reset value of register 29 ($sp)
- Clk  input  1  system clock; all state updates on rising edge
- Rst  input  1  asynchronous, active-high reset
- RegWrite  input  1  writeback enable from MEM/WB
- WriteRegister  input  5  destination register index
- WriteData  input  32  writeback value, the WB-stage mux output
- ReadRegister1  input  5  operand A index (rs)
- ReadRegister2  input  5  operand B index (rt)
- ReadData1  output  32  operand A value, combinational
- ReadData2  output  32  operand B value, combinational
- DebugAddr  input  5  debug read index
- DebugData  output  32  debug read value, registered
- WriteCount  output  32  number of committed register writes

## Operation
- Storage: 32 registers, 32 bits each. Register 0 is not stored; it always reads 32'h0.
- Effective write: RegWrite=1 and WriteRegister!=0. On the rising Clk edge, register[WriteRegister] <= WriteData. A write to register 0 is discarded: no storage change and no count.
- Read port N (N=1,2), combinational:
  - ReadRegisterN==0 -> 32'h0.
  - Else if an effective write is present and WriteRegister==ReadRegisterN -> WriteData (bypass).
  - Else -> register[ReadRegisterN].
- Both read ports are independent; both may hit the bypass in the same cycle.
- Debug port: on each rising edge, DebugData <= the value read port logic would return for DebugAddr, including bypass, so it shows the post-edge contents. Register 0 returns 0.
- WriteCount: increments by 1 on each rising edge with an effective write. Wraps from 32'hFFFF_FFFF to 0.
- Reset, asynchronous on Rst rising and held while Rst=1:
  - All registers go to 0, except register 29, which goes to SP_RESET.
  - DebugData and WriteCount go to 0.
  - Writes are ignored while Rst=1.
  - ReadData1 and ReadData2 reflect the reset contents combinationally. Bypass is suppressed while Rst=1.

## Timing
- Write latency: 1 edge. The value is visible through storage from the cycle after the edge, and through the bypass in the same cycle.
- Read latency: 0 cycles for ReadData1 and ReadData2. DebugData: 1 cycle after DebugAddr is presented.
- Reset is asserted asynchronously and released synchronously upstream. The first write is accepted on the first rising edge with Rst=0.
- Reset mid-operation: a write pending on the same edge at which Rst is asserted is lost. The register keeps its reset value and the count stays 0.
- Simultaneous events:
  - A write and a read of the same index: the read returns the new data.
  - A write to 0 and a read of 0: the read returns 0.
  - Debug and operand reads never interfere.
- No stalls and no handshakes. RegWrite is qualified upstream; this block trusts it every cycle.

## Test plan
- Reset: assert Rst mid-run after several writes -> every ReadRegister index reads 0 except 29, which reads 32'h0000_03FC; WriteCount=0; DebugData=0.
- Write/readback: write 32'hDEAD_BEEF to r8, then 32'h1234_5678 to r31 on the next cycle -> after the edges, ReadRegister1=8 gives DEAD_BEEF and ReadRegister2=31 gives 1234_5678; WriteCount=2.
- Bypass: r9 holds 32'h1. Same cycle: RegWrite=1, WriteRegister=9, WriteData=32'hCAFE_0000, ReadRegister1=ReadRegister2=9 -> both ports read CAFE_0000 before the edge; storage holds CAFE_0000 after the edge.
- $0: write 32'hFFFF_FFFF to r0 with ReadRegister1=0 -> ReadData1=0 before and after the edge; WriteCount unchanged.
- Debug port: DebugAddr=29 after reset -> DebugData=32'h0000_03FC one cycle later. Then write 32'h10 to r29 with DebugAddr=29 -> DebugData=32'h10 after that edge.
- Counter wrap: force WriteCount to 32'hFFFF_FFFF by hierarchical deposit, then perform one effective write -> WriteCount=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Architectural register file: 32 x 32, $0 hardwired to zero, same-cycle
// write-to-read bypass, registered debug read port and a commit counter.
module wb_regfile #(
  parameter logic [31:0] SP_RESET = 32'h0000_03FC
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWrite,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  input  logic [4:0]  DebugAddr,
  output logic [31:0] DebugData,
  output logic [31:0] WriteCount
);

  logic [31:0] regs_q [1:31];
  logic [31:0] debug_q, debug_d;
  logic [31:0] count_q, count_d;
  logic        wr_eff;

  // Reset also gates the bypass, so reads during reset show reset contents.
  assign wr_eff = RegWrite && (WriteRegister != 5'd0) && !Rst;

  function automatic logic [31:0] read_port(input logic [4:0] idx);
    if (idx == 5'd0)
      return 32'h0;
    else if (wr_eff && (WriteRegister == idx))
      return WriteData;
    else
      return regs_q[idx];
  endfunction

  assign ReadData1 = read_port(ReadRegister1);
  assign ReadData2 = read_port(ReadRegister2);

  always_comb begin
    debug_d = read_port(DebugAddr);
    count_d = count_q;
    if (wr_eff)
      count_d = count_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= (i == 29) ? SP_RESET : 32'h0;
    end else if (wr_eff) begin
      regs_q[WriteRegister] <= WriteData;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      debug_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      debug_q <= debug_d;
      count_q <= count_d;
    end
  end

  assign DebugData  = debug_q;
  assign WriteCount = count_q;

endmodule
